matrix_operand_dispatcher: RTL

Initiator side of the row/column/result strobe-acknowledge protocol used by the inner-product units. It holds two N×N single-precision matrices A and B. For each output element C[i][j] in row-major order, it presents row i of A and column j of B to one inner-product unit, waits for the scalar result, and stores it. It sits between the matrix register file and a single inner_product instance, and signals completion of the whole C = A·B product.

---
 rtl/matrix_operand_dispatcher_pkg.sv | 24 ++
 rtl/matrix_operand_dispatcher_operand_slicer.sv | 26 ++
 rtl/matrix_operand_dispatcher.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/matrix_operand_dispatcher_pkg.sv
// Shared state encoding, element width and flat-matrix slice helpers for the operand dispatcher.
package matrix_operand_dispatcher_pkg;

    localparam int ELEM_WORD = 32;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ISSUE    = 3'd1,
        ST_WAIT_RES = 3'd2,
        ST_NEXT     = 3'd3,
        ST_FINISH   = 3'd4
    } state_t;

    // Bit offset of element [row][col] in a row-major flattened n x n matrix of w-bit words.
    function automatic int unsigned flat_base(input int unsigned row, input int unsigned col,
                                              input int unsigned n, input int unsigned w);
        return w * (row * n + col);
    endfunction

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/matrix_operand_dispatcher_operand_slicer.sv
// Combinational: row i of A and column j of B out of the flat matrices; zero latency, no flow control.
module matrix_operand_dispatcher_operand_slicer
    import matrix_operand_dispatcher_pkg::*;
#(
    parameter int N    = 4,
    parameter int WORD = ELEM_WORD,
    parameter int IW   = 2
) (
    input  logic [IW-1:0]       i,
    input  logic [IW-1:0]       j,
    input  logic [WORD*N*N-1:0] a_flat,
    input  logic [WORD*N*N-1:0] b_flat,
    output logic [WORD*N-1:0]   row,
    output logic [WORD*N-1:0]   col
);

    always_comb begin
        row = '0;
        col = '0;
        for (int k = 0; k < N; k++) begin
            row[WORD*k +: WORD] = a_flat[flat_base(32'(i), k, N, WORD) +: WORD];
            col[WORD*k +: WORD] = b_flat[flat_base(k, 32'(j), N, WORD) +: WORD];
        end
    end

endmodule

// File: rtl/matrix_operand_dispatcher.sv
// Strobe/ack initiator computing C = A*B element by element; start->stb 1 clk, >= 4 clk per element.
// Stalls on acks/res_stb indefinitely unless DISPATCH_TIMEOUT_EN adds a per-element watchdog (err).
module matrix_operand_dispatcher
    import matrix_operand_dispatcher_pkg::*;
#(
    parameter int N              = 4,
    parameter int WORD           = ELEM_WORD,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [WORD*N*N-1:0] a_flat,
    input  logic [WORD*N*N-1:0] b_flat,
    output logic [WORD*N-1:0]   row_data,
    output logic                row_stb,
    input  logic                row_ack,
    output logic [WORD*N-1:0]   col_data,
    output logic                col_stb,
    input  logic                col_ack,
    input  logic [WORD-1:0]     res_data,
    input  logic                res_stb,
    output logic                res_ack,
    output logic [WORD*N*N-1:0] c_flat,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam int IW = idx_width(N);

    if (N < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("matrix_operand_dispatcher: N and TIMEOUT_CYCLES must be >= 1");
    end

    state_t              state, state_nxt;
    logic [IW-1:0]       i, j, i_nxt, j_nxt;
    logic [IW-1:0]       adv_i, adv_j, sel_i, sel_j;
    logic                last;
    logic [31:0]         elem_base;
    logic                row_stb_nxt, col_stb_nxt, res_ack_nxt, err_nxt;
    logic [WORD*N-1:0]   row_data_nxt, col_data_nxt, slice_row, slice_col;
    logic [WORD*N*N-1:0] c_flat_nxt;

`ifdef DISPATCH_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo, tmo_nxt;
`endif

    // Slicer looks at the indices about to be latched, so operands and indices update together.
    always_comb begin
        last      = (i == IW'(N - 1)) && (j == IW'(N - 1));
        adv_j     = (j == IW'(N - 1)) ? '0 : j + IW'(1);
        adv_i     = (j == IW'(N - 1)) ? ((i == IW'(N - 1)) ? '0 : i + IW'(1)) : i;
        sel_i     = (state == ST_IDLE) ? '0 : adv_i;
        sel_j     = (state == ST_IDLE) ? '0 : adv_j;
        elem_base = flat_base(32'(i), 32'(j), N, WORD);
    end

    matrix_operand_dispatcher_operand_slicer #(
        .N    (N),
        .WORD (WORD),
        .IW   (IW)
    ) u_slicer (
        .i      (sel_i),
        .j      (sel_j),
        .a_flat (a_flat),
        .b_flat (b_flat),
        .row    (slice_row),
        .col    (slice_col)
    );

    always_comb begin
        state_nxt    = state;
        i_nxt        = i;
        j_nxt        = j;
        row_stb_nxt  = row_stb;
        col_stb_nxt  = col_stb;
        res_ack_nxt  = res_ack;
        row_data_nxt = row_data;
        col_data_nxt = col_data;
        c_flat_nxt   = c_flat;
        err_nxt      = err;
`ifdef DISPATCH_TIMEOUT_EN
        tmo_nxt      = '0;
`endif
        case (state)
            ST_IDLE: begin
                if (start) begin
                    i_nxt        = '0;
                    j_nxt        = '0;
                    row_data_nxt = slice_row;
                    col_data_nxt = slice_col;
                    c_flat_nxt   = '0;
                    row_stb_nxt  = 1'b1;
                    col_stb_nxt  = 1'b1;
                    res_ack_nxt  = 1'b1;
                    err_nxt      = 1'b0;
                    state_nxt    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (row_ack) row_stb_nxt = 1'b0;
                if (col_ack) col_stb_nxt = 1'b0;
                if ((row_ack || !row_stb) && (col_ack || !col_stb)) state_nxt = ST_WAIT_RES;
            end
            ST_WAIT_RES: begin
                if (res_stb) begin
                    c_flat_nxt[elem_base +: WORD] = res_data;
                    res_ack_nxt = 1'b0;
                    state_nxt   = ST_NEXT;
                end
            end
            ST_NEXT: begin
                // A still-high res_stb belongs to the element just stored; wait it out.
                if (!res_stb) begin
                    if (last) begin
                        i_nxt     = '0;
                        j_nxt     = '0;
                        state_nxt = ST_FINISH;
                    end else begin
                        i_nxt        = adv_i;
                        j_nxt        = adv_j;
                        row_data_nxt = slice_row;
                        col_data_nxt = slice_col;
                        row_stb_nxt  = 1'b1;
                        col_stb_nxt  = 1'b1;
                        res_ack_nxt  = 1'b1;
                        state_nxt    = ST_ISSUE;
                    end
                end
            end
            ST_FINISH: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
`ifdef DISPATCH_TIMEOUT_EN
        if (state == ST_ISSUE || state == ST_WAIT_RES) begin
            if (state == ST_WAIT_RES && res_stb) begin
                tmo_nxt = '0;
            end else if (tmo == TW'(TIMEOUT_CYCLES - 1)) begin
                row_stb_nxt = 1'b0;
                col_stb_nxt = 1'b0;
                res_ack_nxt = 1'b0;
                err_nxt     = 1'b1;
                i_nxt       = '0;
                j_nxt       = '0;
                state_nxt   = ST_FINISH;
            end else begin
                tmo_nxt = tmo + TW'(1);
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            i        <= '0;
            j        <= '0;
            row_stb  <= 1'b0;
            col_stb  <= 1'b0;
            res_ack  <= 1'b0;
            row_data <= '0;
            col_data <= '0;
            c_flat   <= '0;
            err      <= 1'b0;
        end else begin
            state    <= state_nxt;
            i        <= i_nxt;
            j        <= j_nxt;
            row_stb  <= row_stb_nxt;
            col_stb  <= col_stb_nxt;
            res_ack  <= res_ack_nxt;
            row_data <= row_data_nxt;
            col_data <= col_data_nxt;
            c_flat   <= c_flat_nxt;
            err      <= err_nxt;
        end
    end

`ifdef DISPATCH_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) tmo <= '0;
        else      tmo <= tmo_nxt;
    end
`endif

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_FINISH);

endmodule
